// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit Fibonacci LFSR: width, taps, next-word function and monitor states.
// Used by the stream monitor, the period meter and the upstream LFSR model.
package lfsr_pkg;

   localparam int LFSR_W = 16;

   // Feedback taps of the generator recurrence; the new bit enters at bit 0.
   localparam int TAP_A = 10;
   localparam int TAP_B = 8;
   localparam int TAP_C = 3;
   localparam int TAP_D = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } monState_t;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
      lfsr_next = {cur[LFSR_W-2:0], cur[TAP_A] ^ cur[TAP_B] ^ cur[TAP_C] ^ cur[TAP_D]};
   endfunction

endpackage

// File: rtl/lfsr_period_meter.sv
// Measures the LFSR sequence period while the monitor is LOCKED: counts matching samples
// between successive returns to the reference word captured on lock entry.
module lfsr_period_meter
   import lfsr_pkg::*;
#(
   parameter int PERIOD_W = 17
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_enter,
   input  logic                i_step,
   input  logic                i_leave,
   input  logic                i_clear,
   input  logic [LFSR_W-1:0]   i_data,
   output logic [PERIOD_W-1:0] o_period,
   output logic                o_periodValid
);

   logic [LFSR_W-1:0]   r_ref;
   logic [PERIOD_W-1:0] r_pcnt;
   logic [PERIOD_W-1:0] r_period;
   logic                r_periodValid;
   logic                w_wrap;

   assign w_wrap = i_step && (i_data == r_ref);

   // Revolution counter restarts at 1 on the reference word itself, so a wrap reports the
   // number of samples in one full cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ref  <= '0;
         r_pcnt <= '0;
      end else if (i_enter) begin
         r_ref  <= i_data;
         r_pcnt <= PERIOD_W'(1);
      end else if (w_wrap) begin
         r_pcnt <= PERIOD_W'(1);
      end else if (i_step && (r_pcnt != '1)) begin
         r_pcnt <= r_pcnt + PERIOD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_period      <= '0;
         r_periodValid <= 1'b0;
      end else if (i_leave) begin
         r_periodValid <= 1'b0;
      end else if (w_wrap) begin
         r_period      <= r_pcnt;
         r_periodValid <= 1'b1;
      end
   end

   assign o_period      = r_period;
   assign o_periodValid = r_periodValid;

endmodule

// File: rtl/lfsr_stream_monitor.sv
// Checks an upstream 16-bit Fibonacci LFSR stream: locks onto the sequence, counts recurrence
// violations and flags the all-zero word. Define LFSR_STREAM_MONITOR_PERIOD_EN for period measurement.
module lfsr_stream_monitor
   import lfsr_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int ERR_W      = 16
`ifdef LFSR_STREAM_MONITOR_PERIOD_EN
   ,
   parameter int PERIOD_W   = 17
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid,
   input  logic [LFSR_W-1:0] data,
   input  logic              clear,
   output logic              locked,
   output logic              err_pulse,
   output logic [ERR_W-1:0]  err_count,
   output logic              stuck
`ifdef LFSR_STREAM_MONITOR_PERIOD_EN
   ,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid
`endif
);

   localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

   monState_t         r_state;
   monState_t         w_stateNext;
   logic [3:0]        r_matchCnt;
   logic [3:0]        w_matchCntNext;
   logic [3:0]        w_cntInc;
   logic [LFSR_W-1:0] r_prev;
   logic [LFSR_W-1:0] w_pred;
   logic              w_match;
   logic              w_lockedErr;
   logic              r_locked;
   logic              r_errPulse;
   logic              r_stuck;
   logic [ERR_W-1:0]  r_errCount;

   // A zero word is the stuck state of the generator and never counts as a correct prediction.
   assign w_pred      = lfsr_next(r_prev);
   assign w_match     = (data == w_pred) && (data != '0);
   assign w_cntInc    = r_matchCnt + 4'd1;
   assign w_lockedErr = valid && (r_state == ST_LOCKED) && !w_match;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_matchCnt <= '0;
      end else begin
         r_state    <= w_stateNext;
         r_matchCnt <= w_matchCntNext;
      end
   end

   always_comb begin
      w_stateNext    = r_state;
      w_matchCntNext = r_matchCnt;
      if (valid) begin
         case (r_state)
            ST_IDLE: begin
               w_stateNext    = ST_SYNC;
               w_matchCntNext = '0;
            end
            ST_SYNC: begin
               if (w_match) begin
                  w_matchCntNext = w_cntInc;
                  if (w_cntInc == LOCK_TARGET) begin
                     w_stateNext = ST_LOCKED;
                  end
               end else begin
                  w_matchCntNext = '0;
               end
            end
            ST_LOCKED: begin
               if (!w_match) begin
                  w_stateNext    = ST_SYNC;
                  w_matchCntNext = '0;
               end
            end
            default: begin
               w_stateNext    = ST_IDLE;
               w_matchCntNext = '0;
            end
         endcase
      end
   end

   // Clear takes priority over a simultaneous error or zero word, but the error pulse still fires.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev     <= '0;
         r_locked   <= 1'b0;
         r_errPulse <= 1'b0;
         r_errCount <= '0;
         r_stuck    <= 1'b0;
      end else begin
         if (valid) begin
            r_prev <= data;
         end
         r_locked   <= (w_stateNext == ST_LOCKED);
         r_errPulse <= w_lockedErr;
         if (clear) begin
            r_errCount <= '0;
         end else if (w_lockedErr && (r_errCount != '1)) begin
            r_errCount <= r_errCount + ERR_W'(1);
         end
         if (clear) begin
            r_stuck <= 1'b0;
         end else if (valid && (data == '0)) begin
            r_stuck <= 1'b1;
         end
      end
   end

   assign locked    = r_locked;
   assign err_pulse = r_errPulse;
   assign err_count = r_errCount;
   assign stuck     = r_stuck;

`ifdef LFSR_STREAM_MONITOR_PERIOD_EN
   logic w_enterLock;
   logic w_lockedMatch;

   assign w_enterLock   = valid && (r_state == ST_SYNC) && w_match && (w_cntInc == LOCK_TARGET);
   assign w_lockedMatch = valid && (r_state == ST_LOCKED) && w_match;

   lfsr_period_meter #(
      .PERIOD_W(PERIOD_W)
   ) uPeriodMeter (
      .clk           (clk),
      .reset         (reset),
      .i_enter       (w_enterLock),
      .i_step        (w_lockedMatch),
      .i_leave       (w_lockedErr),
      .i_clear       (clear),
      .i_data        (data),
      .o_period      (period),
      .o_periodValid (period_valid)
   );
`endif

endmodule

// File: tb/tb_lfsr_stream_monitor.sv
// Self-checking bench for lfsr_stream_monitor: directed lock/error/zero/saturation scenarios plus
// randomized traffic, compared every cycle against a sample-level behavioural model.
module tb_lfsr_stream_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid;
   logic        clear;
   logic [15:0] data;

   logic        locked, errPulse, stuck;
   logic [15:0] errCount;
   logic        lockedSat, errPulseSat, stuckSat;
   logic [1:0]  errCountSat;
`ifdef LFSR_STREAM_MONITOR_PERIOD_EN
   logic [16:0] period, periodSat;
   logic        periodValid, periodValidSat;
`endif

   int testsRun    = 0;
   int testsFailed = 0;

   // Behavioural model: run length of consecutive correct predictions and error tally.
   bit          mHave, mLocked, mStuck, mPulse;
   int          mRun, mErr;
   logic [15:0] mPrev;
   logic [15:0] lastWord = 16'h0001;

   always #5 clk = ~clk;

   lfsr_stream_monitor dut (
      .clk(clk), .reset(reset), .valid(valid), .data(data), .clear(clear),
      .locked(locked), .err_pulse(errPulse), .err_count(errCount), .stuck(stuck)
`ifdef LFSR_STREAM_MONITOR_PERIOD_EN
      , .period(period), .period_valid(periodValid)
`endif
   );

   lfsr_stream_monitor #(.LOCK_COUNT(4), .ERR_W(2)) dutSat (
      .clk(clk), .reset(reset), .valid(valid), .data(data), .clear(clear),
      .locked(lockedSat), .err_pulse(errPulseSat), .err_count(errCountSat), .stuck(stuckSat)
`ifdef LFSR_STREAM_MONITOR_PERIOD_EN
      , .period(periodSat), .period_valid(periodValidSat)
`endif
   );

   function automatic logic [15:0] refNext(input logic [15:0] w);
      return {w[14:0], ^(w & 16'h050A)};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mHave = 0; mLocked = 0; mStuck = 0; mPulse = 0; mRun = 0; mErr = 0; mPrev = '0;
   endtask

   task automatic modelStep(input logic v, input logic [15:0] d, input logic c);
      bit ok;
      mPulse = 0;
      if (v) begin
         ok = mHave && (d == refNext(mPrev)) && (d != 16'h0000);
         if (!mHave) begin
            mHave = 1;
            mRun  = 0;
         end else if (mLocked) begin
            if (!ok) begin
               mPulse  = 1;
               mErr++;
               mLocked = 0;
               mRun    = 0;
            end
         end else if (ok) begin
            mRun++;
            if (mRun == 4) mLocked = 1;
         end else begin
            mRun = 0;
         end
         if (d == 16'h0000) mStuck = 1;
         mPrev = d;
      end
      if (c) begin
         mErr   = 0;
         mStuck = 0;
      end
   endtask

   task automatic compareAll();
      checkOutput("locked",      32'(locked),      32'(mLocked));
      checkOutput("lockedSat",   32'(lockedSat),   32'(mLocked));
      checkOutput("errPulse",    32'(errPulse),    32'(mPulse));
      checkOutput("errPulseSat", 32'(errPulseSat), 32'(mPulse));
      checkOutput("errCount",    32'(errCount),    32'((mErr > 65535) ? 65535 : mErr));
      checkOutput("errCountSat", 32'(errCountSat), 32'((mErr > 3) ? 3 : mErr));
      checkOutput("stuck",       32'(stuck),       32'(mStuck));
      checkOutput("stuckSat",    32'(stuckSat),    32'(mStuck));
   endtask

   // Called at a falling edge: drive, let the rising edge sample, check at the next falling edge.
   task automatic applyStimulus(input logic v, input logic [15:0] d, input logic c);
      valid = v; data = d; clear = c;
      @(posedge clk);
      modelStep(v, d, c);
      if (v) lastWord = d;
      @(negedge clk);
      compareAll();
   endtask

   task automatic doReset();
      reset = 1'b1; valid = 1'b0; clear = 1'b0; data = '0;
      @(posedge clk);
      modelReset();
      @(negedge clk);
      reset = 1'b0;
      compareAll();
   endtask

   task automatic sendNext();
      applyStimulus(1'b1, refNext(lastWord), 1'b0);
   endtask

   task automatic injectBad(input logic c);
      logic [15:0] bad;
      bad = ~refNext(lastWord);
      if (bad == 16'h0000) bad = 16'h0001;
      applyStimulus(1'b1, bad, c);
   endtask

   task automatic lockFromSeed(input int gaps);
      logic [15:0] words [5];
      words = '{16'h0001, 16'h0002, 16'h0005, 16'h000A, 16'h0014};
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, words[i], 1'b0);
         if (i < 4) checkOutput("noEarlyLock", 32'(locked), 32'd0);
         if (i < 4) begin
            for (int g = 0; g < gaps; g++) applyStimulus(1'b0, 16'($urandom), 1'b0);
         end
      end
      checkOutput("lockSeed", 32'(locked), 32'd1);
      checkOutput("lockSeedErr", 32'(errCount), 32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] x, s;
      int          lenRef, n, r;
      logic        v, c;
      logic [15:0] d;

      reset = 1'b1; valid = 1'b0; clear = 1'b0; data = '0;
      modelReset();
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         x = 16'($urandom);
         checkOutput("pkgNext", 32'(lfsr_pkg::lfsr_next(x)), 32'(refNext(x)));
      end

      doReset();
      checkOutput("rstLocked",   32'(locked),   32'd0);
      checkOutput("rstErrPulse", 32'(errPulse), 32'd0);
      checkOutput("rstErrCount", 32'(errCount), 32'd0);
      checkOutput("rstStuck",    32'(stuck),    32'd0);

      // Lock from seed, then an injected error and relock.
      lockFromSeed(0);
      applyStimulus(1'b1, 16'h0028, 1'b0);
      checkOutput("stillLocked", 32'(locked), 32'd1);
      applyStimulus(1'b1, 16'h1234, 1'b0);
      checkOutput("injPulse",  32'(errPulse), 32'd1);
      checkOutput("injCount",  32'(errCount), 32'd1);
      checkOutput("injLocked", 32'(locked),   32'd0);
      applyStimulus(1'b1, 16'h2468, 1'b0);
      checkOutput("pulseOneCycle", 32'(errPulse), 32'd0);
      applyStimulus(1'b1, 16'h48D0, 1'b0);
      applyStimulus(1'b1, 16'h91A0, 1'b0);
      checkOutput("notYetRelocked", 32'(locked), 32'd0);
      applyStimulus(1'b1, 16'h2341, 1'b0);
      checkOutput("relocked",   32'(locked),   32'd1);
      checkOutput("relockErrs", 32'(errCount), 32'd1);

      // Valid gaps between samples must not change the lock point.
      doReset();
      lockFromSeed(3);
      for (int g = 0; g < 3; g++) applyStimulus(1'b0, 16'h0000, 1'b0);
      checkOutput("gapHoldLock", 32'(locked), 32'd1);
      checkOutput("gapStuck",    32'(stuck),  32'd0);

      // Zero word in SYNC.
      doReset();
      applyStimulus(1'b1, 16'h0001, 1'b0);
      applyStimulus(1'b1, 16'h0002, 1'b0);
      applyStimulus(1'b1, 16'h0000, 1'b0);
      checkOutput("zeroStuck", 32'(stuck), 32'd1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0000, 1'b0);
      checkOutput("zeroNoLock", 32'(locked), 32'd0);
      applyStimulus(1'b0, 16'h0000, 1'b1);
      checkOutput("zeroCleared", 32'(stuck), 32'd0);
      applyStimulus(1'b1, 16'h0000, 1'b1);
      checkOutput("zeroWithClear", 32'(stuck), 32'd0);

      // Saturation of the 2-bit counter and clear racing a mismatch.
      doReset();
      applyStimulus(1'b1, 16'h0001, 1'b0);
      for (int k = 0; k < 5; k++) begin
         repeat (4) sendNext();
         injectBad(1'b0);
      end
      checkOutput("satCount2",  32'(errCountSat), 32'd3);
      checkOutput("satCount16", 32'(errCount),    32'd5);
      repeat (4) sendNext();
      injectBad(1'b1);
      checkOutput("clrErrCount", 32'(errCount),    32'd0);
      checkOutput("clrErrSat",   32'(errCountSat), 32'd0);
      checkOutput("clrErrPulse", 32'(errPulse),    32'd1);

      // Randomized traffic with occasional clears and resets.
      for (int i = 0; i < 800; i++) begin
         r = int'($urandom_range(0, 99));
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 49) == 0);
         if (r < 80 && lastWord != 16'h0000) d = refNext(lastWord);
         else if (r < 96)                    d = 16'($urandom_range(1, 65535));
         else                                d = 16'h0000;
         if ($urandom_range(0, 199) == 0) doReset();
         else                             applyStimulus(v, d, c);
      end

`ifdef LFSR_STREAM_MONITOR_PERIOD_EN
      // Start on a word that lies on the cycle (early words of a seed may sit on a tail).
      doReset();
      s = 16'h0001;
      repeat (16) s = refNext(s);
      applyStimulus(1'b1, s, 1'b0);
      repeat (4) sendNext();
      checkOutput("perLocked", 32'(locked), 32'd1);
      x      = refNext(lastWord);
      lenRef = 1;
      while (x != lastWord && lenRef < 70000) begin
         x = refNext(x);
         lenRef++;
      end
      n = 0;
      while (periodValid !== 1'b1 && n < lenRef + 8) begin
         sendNext();
         n++;
      end
      checkOutput("periodValid",   32'(periodValid), 32'd1);
      checkOutput("periodLen",     32'(period),      32'(lenRef));
      checkOutput("periodSamples", 32'(n),           32'(lenRef));
      checkOutput("periodLenSat",  32'(periodSat),   32'(lenRef));
      applyStimulus(1'b1, refNext(lastWord), 1'b1);
      checkOutput("periodClear",      32'(period),      32'd0);
      checkOutput("periodValidClear", 32'(periodValid), 32'd0);
      repeat (10) sendNext();
      doReset();
      checkOutput("perRstPeriod", 32'(period),      32'd0);
      checkOutput("perRstValid",  32'(periodValid), 32'd0);
      checkOutput("perRstLocked", 32'(locked),      32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/lfsr_stream_monitor.md
# lfsr_stream_monitor

Checks the 16-bit Fibonacci LFSR stream and confirms that every word follows the generator's recurrence. It sits directly downstream of the LFSR stage and samples that stage's output word.
- Locks onto the sequence from any seed.
- Counts recurrence violations.
- Flags the all-zero stuck state.
- Optionally measures the sequence period.

## Interface
Parameters:
- LOCK_COUNT, 4: consecutive correct predictions required to declare lock (range 1–15).
- ERR_W, 16: width of the error counter. The counter saturates.
- PERIOD_W, 17: width of the period counter. The counter saturates.

Ports:
- clk  in  1  rising-edge clock. The upstream LFSR updates on the falling edge, so data is stable at each rising edge.
- reset  in  1  reset, synchronous, active-high.
- valid  in  1  data carries a new LFSR word this cycle. Tie high for free-running use.
- data  in  16  LFSR word from the upstream stage.
- clear  in  1  synchronous clear of err_count, stuck and the period result. The state machine is unaffected.
- locked  out  1  monitor is in the LOCKED state.
- err_pulse  out  1  one-cycle pulse for each mismatch detected while LOCKED.
- err_count  out  ERR_W  number of mismatches detected while LOCKED. Saturates at all-ones.
- stuck  out  1  sticky flag: a valid word equal to 16'h0000 was seen.
- period  out  PERIOD_W  last measured period. Present only with the macro.
- period_valid  out  1  period holds a completed measurement. Present only with the macro.

## Operation
- Prediction: pred = {prev[14:0], prev[10]^prev[8]^prev[3]^prev[1]}.
  - prev is the last accepted word.
  - A sample matches when data == pred and data != 0. A zero word never matches.
- Every valid sample loads prev <= data, whatever the state.
- States: IDLE, SYNC, LOCKED. All transitions happen on valid samples only; when valid=0 everything holds.
  - IDLE, valid: capture prev; match_cnt <= 0; go to SYNC.
  - SYNC, match: match_cnt + 1. When this reaches LOCK_COUNT, go to LOCKED.
  - SYNC, mismatch: match_cnt <= 0; stay in SYNC. No error is counted.
  - LOCKED, match: stay.
  - LOCKED, mismatch: pulse err_pulse; increment err_count (saturating); match_cnt <= 0; go to SYNC. The mismatching word becomes the new prev.
- stuck sets on any valid word equal to 0. It clears only on reset or clear.
- Simultaneous events:
  - clear together with a LOCKED mismatch: err_count <= 0 (clear wins), but err_pulse still fires.
  - clear together with a zero word: stuck stays 0.
- Reset during operation: return to IDLE, and all outputs and counters go to 0 on the next edge.

## Timing
- Every output is registered. A sample at rising edge N shows its effect in the cycle after edge N, i.e. one cycle of latency.
- locked rises in the cycle after the LOCK_COUNT-th matching sample. It falls in the cycle after a LOCKED mismatch.
- err_pulse is high for exactly one cycle per mismatch.
- Reset values of all outputs: locked=0, err_pulse=0, err_count=0, stuck=0, period=0, period_valid=0.

## Configuration
- LFSR_STREAM_MONITOR_PERIOD_EN defined:
  - Measurement starts on the edge that enters LOCKED: ref <= data, pcnt <= 1.
  - Each later matching sample increments pcnt (saturating).
  - When data == ref: period <= pcnt, period_valid <= 1, pcnt <= 1. This repeats every revolution.
  - On leaving LOCKED: period_valid <= 0; period keeps its last value.
  - clear zeroes both period and period_valid.
- Macro undefined: the period and period_valid ports and all period logic are absent.

## Structure
- Shared package lfsr_pkg contains:
  - LFSR_W = 16.
  - The tap localparams.
  - Function lfsr_next(logic [15:0]). The upstream LFSR model and testbenches use the same function.
  - The monitor state enum.
- Sub-module lfsr_period_meter holds ref, pcnt and the period registers. It is instantiated only under the macro.

## Test plan
- Lock from seed: run upstream with init=16'hFFFE (out=16'h0001). Stream 0001, 0002, 0005, 000A, 0014 with valid=1. Required: locked=1 in the cycle after 0014; err_count=0.
- Injected error: after lock, send 0028 then 1234. Required: one err_pulse; err_count=1; locked=0. Then 2468, 48D0, 91A0, 2341 must relock (recompute expected words with lfsr_next).
- Valid gaps: lock sequence with valid=0 for 3 cycles between words. Required: same lock point counted in samples, with no errors.
- Zero word: send 0000 in SYNC. Required: stuck=1; no lock. After clear: stuck=0.
- Saturation/clear: ERR_W=2, force 5 LOCKED mismatches. Required: err_count=3. clear together with a mismatch gives err_count=0 and err_pulse=1.
- Period (macro on): free-run the true LFSR from 0001 until period_valid. Required: period equals the reference-model cycle length, and reset mid-measurement returns all outputs to 0.
